// File: rtl/pulse_meas_arbiter_if.sv
// Channel-side bundle of the pulse measurement arbiter: per-channel requests and
// pulses in, shared-counter controls and status out.
interface pulse_meas_arbiter_if #(
  parameter int NCH = 4
);
  localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]   REQ;
  logic [NCH-1:0]   PULSE_A;
  logic [NCH-1:0]   PULSE_B;
  logic             INC;
  logic             SCLR;
  logic             LOAD;
  logic [NCH-1:0]   GRANT;
  logic [SEL_W-1:0] LOAD_SEL;
  logic             DONE;
  logic             TMO_ERR;
  logic             BUSY;

  modport master (
    input  REQ, PULSE_A, PULSE_B,
    output INC, SCLR, LOAD, GRANT, LOAD_SEL, DONE, TMO_ERR, BUSY
  );

  modport slave (
    output REQ, PULSE_A, PULSE_B,
    input  INC, SCLR, LOAD, GRANT, LOAD_SEL, DONE, TMO_ERR, BUSY
  );
endinterface

// File: rtl/pulse_meas_arbiter.sv
// Round-robin owner of one shared interval counter: grants a channel, clears the
// counter, counts from start pulse to stop pulse, then loads or aborts on watchdog.
module pulse_meas_arbiter #(
  parameter int NCH         = 4,
  parameter int TMO_W       = 16,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                  SYS_CLK,
  input  logic                  A_RESET_N,
  pulse_meas_arbiter_if.master  bus
);
  localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_WAIT_A = 3'd2;
  localparam logic [2:0] S_ARMED  = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_LOAD   = 3'd5;
  localparam logic [2:0] S_ABORT  = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [SEL_W-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] start_q, start_d;
  logic [TMO_W-1:0] wd_q, wd_d;
  logic [SEL_W-1:0] win;
  logic             found;
  logic             pa, pb, expire;
  logic [SEL_W-1:0] gnt_next;

  // Scan channels starting at the slot after the last owner.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NCH; i++) begin : scan
      int j;
      j = int'(start_q) + i;
      if (j >= NCH) j = j - NCH;
      if (!found && bus.REQ[j]) begin
        found = 1'b1;
        win   = SEL_W'(j);
      end
    end
  end

  assign pa       = bus.PULSE_A[gnt_q];
  assign pb       = bus.PULSE_B[gnt_q];
  assign expire   = (wd_q == TMO_W'(TIMEOUT_CYC - 1));
  assign gnt_next = (gnt_q == SEL_W'(NCH - 1)) ? '0 : gnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    start_d = start_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE: if (found) begin
        gnt_d   = win;
        state_d = S_CLR;
      end
      S_CLR: begin
        wd_d    = '0;
        state_d = S_WAIT_A;
      end
      S_WAIT_A: begin
        wd_d = wd_q + 1'b1;
        if (expire)  state_d = S_ABORT;
        else if (pa) state_d = S_ARMED;
      end
      S_ARMED: begin
        wd_d = wd_q + 1'b1;
        if (expire)   state_d = S_ABORT;
        else if (!pa) state_d = S_RUN;
      end
      S_RUN: begin
        wd_d = wd_q + 1'b1;
        // A stop pulse coinciding with expiry still counts as a measurement.
        if (pb)          state_d = S_LOAD;
        else if (expire) state_d = S_ABORT;
      end
      S_LOAD, S_ABORT: begin
        start_d = gnt_next;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge A_RESET_N) begin
    if (!A_RESET_N) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      start_q <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      start_q <= start_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.BUSY     = (state_q != S_IDLE);
  assign bus.SCLR     = (state_q == S_CLR);
  assign bus.INC      = (state_q == S_ARMED) || (state_q == S_RUN);
  assign bus.LOAD     = (state_q == S_LOAD);
  assign bus.DONE     = (state_q == S_LOAD);
  assign bus.TMO_ERR  = (state_q == S_ABORT);
  assign bus.GRANT    = bus.BUSY ? (NCH'(1) << gnt_q) : '0;
  assign bus.LOAD_SEL = bus.BUSY ? gnt_q : '0;
endmodule

// File: tb/tb_pulse_meas_arbiter.sv
// Directed bench: stimulus tasks queue the expected outcome of each measurement,
// a negedge monitor pops and compares when DONE or TMO_ERR appears.
module tb_pulse_meas_arbiter;
  localparam int NCH = 4;
  localparam int TMO = 20;

  typedef struct {
    int ch;
    int inc;
    bit tmo;
  } exp_t;

  logic SYS_CLK   = 1'b0;
  logic A_RESET_N = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  pulse_meas_arbiter_if #(.NCH(NCH)) bus ();

  pulse_meas_arbiter #(.NCH(NCH), .TMO_W(16), .TIMEOUT_CYC(TMO)) dut (
    .SYS_CLK   (SYS_CLK),
    .A_RESET_N (A_RESET_N),
    .bus       (bus)
  );

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t q[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Monitor
  int             inc_cnt  = 0;
  int             sclr_cnt = 0;
  bit             g_chg    = 0;
  logic [NCH-1:0] g_clr    = '0;

  always @(negedge SYS_CLK) begin
    exp_t e;
    if (!A_RESET_N) begin
      inc_cnt = 0; sclr_cnt = 0; g_chg = 0;
    end else if (bus.BUSY) begin
      if (bus.SCLR) begin
        sclr_cnt++;
        g_clr = bus.GRANT;
      end else if (bus.GRANT !== g_clr) g_chg = 1;
      if (bus.INC) inc_cnt++;
      if (bus.DONE || bus.TMO_ERR) begin
        if (q.size() == 0) chk("unexpected_end", 1, 0);
        else begin
          e = q.pop_front();
          chk("load_sel",   int'(bus.LOAD_SEL), e.ch);
          chk("grant",      int'(bus.GRANT), 1 << e.ch);
          chk("inc_cycles", inc_cnt, e.inc);
          chk("tmo_err",    int'(bus.TMO_ERR), int'(e.tmo));
          chk("done",       int'(bus.DONE), int'(!e.tmo));
          chk("load",       int'(bus.LOAD), int'(!e.tmo));
          chk("sclr_once",  sclr_cnt, 1);
          chk("grant_held", int'(g_chg), 0);
        end
        inc_cnt = 0; sclr_cnt = 0; g_chg = 0;
      end
    end
  end

  task automatic wait_sclr(output bit ok);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge SYS_CLK);
      ok = bus.SCLR;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge SYS_CLK);
      ok = !bus.BUSY;
    end
    if (!ok) chk("wait_idle", 0, 1);
  endtask

  // Start pulse high for a_len cycles from the first WAIT_A cycle; stop pulse on
  // cycle a_len+r. Without a stop pulse the watchdog runs out after TMO cycles.
  task automatic meas(input logic [NCH-1:0] req, input int ch, input int a_len,
                      input int r, input bit use_b, input bit noise, input bit hold);
    exp_t           e;
    int             n;
    bit             ok;
    logic [NCH-1:0] oh, pa, pb;
    oh    = NCH'(1) << ch;
    e.ch  = ch;
    e.inc = use_b ? a_len + r - 1 : TMO - 1;
    e.tmo = !use_b;
    q.push_back(e);
    n = use_b ? a_len + r : TMO;
    bus.REQ = req;
    wait_sclr(ok);
    if (!ok) begin
      chk("wait_sclr", 0, 1);
      void'(q.pop_back());
      return;
    end
    if (!hold) bus.REQ = '0;
    @(posedge SYS_CLK); #1;
    for (int c = 1; c <= n; c++) begin
      pa = (c <= a_len) ? oh : '0;
      pb = ((use_b && c == n) || (noise && c >= 2 && c <= a_len)) ? oh : '0;
      if (noise) begin
        pa = pa | ~oh;
        pb = pb | ~oh;
      end
      bus.PULSE_A = pa;
      bus.PULSE_B = pb;
      @(posedge SYS_CLK); #1;
    end
    bus.PULSE_A = '0;
    bus.PULSE_B = '0;
    wait_idle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_inc"},      int'(bus.INC), 0);
    chk({tag, "_sclr"},     int'(bus.SCLR), 0);
    chk({tag, "_load"},     int'(bus.LOAD), 0);
    chk({tag, "_done"},     int'(bus.DONE), 0);
    chk({tag, "_tmo"},      int'(bus.TMO_ERR), 0);
    chk({tag, "_busy"},     int'(bus.BUSY), 0);
    chk({tag, "_grant"},    int'(bus.GRANT), 0);
    chk({tag, "_load_sel"}, int'(bus.LOAD_SEL), 0);
  endtask

  initial begin
    bit ok;
    bus.REQ     = '0;
    bus.PULSE_A = '0;
    bus.PULSE_B = '0;
    #12;
    chk_all_zero("rst");
    @(posedge SYS_CLK); #1;
    A_RESET_N = 1'b1;
    @(negedge SYS_CLK);
    chk("idle_busy", int'(bus.BUSY), 0);

    // Round-robin from reset with all channels requesting
    meas(4'b1111, 0, 1, 2, 1, 0, 1);
    meas(4'b1111, 1, 1, 2, 1, 0, 1);
    meas(4'b1111, 2, 1, 2, 1, 0, 1);
    meas(4'b1111, 3, 1, 2, 1, 0, 1);
    meas(4'b1111, 0, 1, 2, 1, 0, 0);

    // Start pulse 3 cycles, INC for 8 cycles, request dropped after grant
    meas(4'b0100, 2, 3, 6, 1, 0, 0);
    // Stop pulse during ARMED and activity on other channels is ignored
    meas(4'b1000, 3, 3, 4, 1, 1, 0);
    // Stop pulse on the watchdog expiry edge wins
    meas(4'b0010, 1, 1, 19, 1, 0, 0);
    // Watchdog abort, then the pointer moves past the aborted channel
    meas(4'b0001, 0, 1, 0, 0, 0, 0);
    meas(4'b1111, 1, 2, 3, 1, 0, 0);

    // Reset in the middle of RUN
    bus.REQ = 4'b0100;
    wait_sclr(ok);
    chk("rst_run_sclr", int'(ok), 1);
    bus.REQ = '0;
    @(posedge SYS_CLK); #1;
    bus.PULSE_A = 4'b0100;
    @(posedge SYS_CLK); #1;
    bus.PULSE_A = '0;
    @(posedge SYS_CLK); #1;
    @(posedge SYS_CLK); #1;
    chk("run_inc",   int'(bus.INC), 1);
    chk("run_grant", int'(bus.GRANT), 4);
    A_RESET_N = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(posedge SYS_CLK);
    #1;
    A_RESET_N = 1'b1;
    meas(4'b1010, 1, 2, 3, 1, 0, 0);

    repeat (5) @(posedge SYS_CLK);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end
endmodule

// File: doc/pulse_meas_arbiter.md
PULSE_MEAS_ARBITER -- requirements
Module: pulse_meas_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 4, number of transmitter/receiver channels sharing one interval counter.
REQ-002 SHALL have parameter TMO_W, default 16, width of the internal watchdog counter.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1000, watchdog limit in SYS_CLK cycles (1 to 2^TMO_W-1).
REQ-004 SHALL have port SYS_CLK  in  1  single system clock, all state on rising edge.
REQ-005 SHALL have port A_RESET_N  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port REQ  in  NCH  per-channel measurement request, level.
REQ-007 SHALL have port PULSE_A  in  NCH  per-channel transmit (start) pulse, synchronous to SYS_CLK.
REQ-008 SHALL have port PULSE_B  in  NCH  per-channel receive (stop) pulse, synchronous to SYS_CLK.
REQ-009 SHALL have port INC  out  1  shared counter increment enable.
REQ-010 SHALL have port SCLR  out  1  shared counter synchronous clear.
REQ-011 SHALL have port LOAD  out  1  capture shared counter into the result register selected by LOAD_SEL.
REQ-012 SHALL have port GRANT  out  NCH  one-hot owner of the shared counter, all-zero when idle.
REQ-013 SHALL have port LOAD_SEL  out  clog2(NCH)  index of the granted channel.
REQ-014 SHALL have port DONE  out  1  one-cycle pulse, measurement completed.
REQ-015 SHALL have port TMO_ERR  out  1  one-cycle pulse, measurement aborted by watchdog.
REQ-016 SHALL have port BUSY  out  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, CLR, WAIT_A, ARMED, RUN, LOAD, ABORT; all outputs decoded from present state and granted index only (Moore).
REQ-018 IDLE: any REQ bit high at an edge -> latch winner index, go CLR; otherwise stay.
REQ-019 Winner SHALL be round-robin: search starts at (last granted index + 1) mod NCH; after reset, channel 0 has highest priority.
REQ-020 CLR: SCLR=1 for exactly one cycle -> WAIT_A.
REQ-021 WAIT_A: PULSE_A[g] high -> ARMED; else stay.
REQ-022 ARMED: INC=1; PULSE_A[g] high -> stay; low -> RUN; PULSE_B[g] ignored.
REQ-023 RUN: INC=1; PULSE_B[g] high -> LOAD; else stay.
REQ-024 LOAD: LOAD=1 and DONE=1 for one cycle -> IDLE; pointer updated to g.
REQ-025 ABORT: TMO_ERR=1 for one cycle, LOAD=0 -> IDLE; pointer updated to g.
REQ-026 GRANT[g]=1 and LOAD_SEL=g held from CLR through LOAD/ABORT inclusive; GRANT=0, LOAD_SEL=0 in IDLE.
REQ-027 Watchdog SHALL clear in CLR, count each cycle in WAIT_A, ARMED, RUN, and force ABORT at the edge where it has counted TIMEOUT_CYC cycles.
REQ-028 PULSE_B[g] in RUN on the same edge as watchdog expiry SHALL go to LOAD (measurement wins).
REQ-029 Pulses and REQ on non-granted channels SHALL be ignored; REQ[g] dropping after grant SHALL not abort the measurement.
REQ-030 Minimum IDLE dwell between measurements SHALL be one cycle.

Reset
REQ-031 A_RESET_N low SHALL immediately force IDLE, INC=SCLR=LOAD=DONE=TMO_ERR=BUSY=0, GRANT=0, LOAD_SEL=0, watchdog=0, pointer to channel 0 priority, including mid-measurement.
REQ-032 First REQ evaluation SHALL occur on the first rising edge after A_RESET_N deasserts.

Verification
REQ-033 NCH=4, REQ=0100, PULSE_A[2] high 3 cycles, PULSE_B[2] 5 cycles later -> GRANT=0100, SCLR 1 cycle, INC 8 cycles, LOAD=DONE 1 cycle with LOAD_SEL=2, then IDLE.
REQ-034 REQ=1111 held, each measurement completed -> grant order 0,1,2,3,0.
REQ-035 TIMEOUT_CYC=20, REQ=0001, PULSE_A[0] only, no PULSE_B -> TMO_ERR after 20 watchdog cycles, LOAD never asserted, next REQ=1111 grants channel 1.
REQ-036 PULSE_B[g] during ARMED and PULSE_A/B on channel !=g -> no state change, INC unaffected.
REQ-037 PULSE_B[g] on the edge of watchdog expiry -> LOAD/DONE, no TMO_ERR.
REQ-038 A_RESET_N low during RUN -> all outputs 0 asynchronously; after release, REQ=1010 grants channel 1.
